idex_pipeline_register: RTL and testbench
=========================================

Name: idex_pipeline_register

Overview:
- ID/EX pipeline register between decode and execute in the 5-stage LEGv8 pipeline.
- Captures decoded control and operands from ID and feeds EX.
- Sources IDEX_MemRead/IDEX_rd back to the load-use hazard detector.
- Consumes the detector's Stall_flush to insert bubbles; also handles branch-redirect flush, downstream hold and bubble/flush performance counters.

Parameters:
DATA_WIDTH, 64, width of PC, register operands and sign-extended immediate
REG_ADDR_WIDTH, 5, register specifier width
CNT_WIDTH, 32, width of each performance counter

Ports:
Clk  input  1  clock; all state updates on rising edge
Reset_n  input  1  synchronous active-low reset
IFID_Valid  input  1  ID stage holds a real instruction
Stall_flush  input  1  load-use bubble request from hazard detection
Branch_flush  input  1  taken-branch redirect from EX/MEM; kills the instruction entering ID/EX
IDEX_Hold  input  1  downstream stall; freeze ID/EX contents
ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_Branch, ID_UncondBranch  input  1 each  decoded control
ID_ALUOp  input  2  decoded ALU op class
ID_PC  input  DATA_WIDTH  instruction PC
ID_ReadData1, ID_ReadData2  input  DATA_WIDTH  register file outputs
ID_SignExtImm  input  DATA_WIDTH  sign-extended immediate
ID_Opcode  input  11  instruction[31:21] for ALU control
ID_rn, ID_rm, ID_rd  input  REG_ADDR_WIDTH  register specifiers
IDEX_* (Valid, RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Branch, UncondBranch, ALUOp, PC, ReadData1, ReadData2, SignExtImm, Opcode, rn, rm, rd)  output  matching widths  registered copies
Bubble_Count  output  CNT_WIDTH  bubbles inserted due to Stall_flush
Flush_Count  output  CNT_WIDTH  valid instructions killed by Branch_flush

Behaviour:
- Single-cycle latency: values present at edge N appear on IDEX_* after edge N.
- Each edge performs exactly one action, chosen by this priority:
  1. Reset.
  2. Branch_flush.
  3. IDEX_Hold.
  4. Stall_flush.
  5. Load.
- Reset (Reset_n=0 at edge):
  - All outputs go to 0, except IDEX_rn/rm/rd = 31 (XZR).
  - Both counters go to 0.
  - Reset mid-stream discards any in-flight instruction.
- Bubble contents (used by Branch_flush and by Stall_flush):
  - IDEX_Valid and all control outputs = 0; IDEX_ALUOp = 0.
  - IDEX_rn/rm/rd = 31, so the bubble never matches the hazard or forwarding compare.
  - Data outputs (PC, ReadData1/2, SignExtImm, Opcode) hold their previous values.
- Branch_flush=1:
  - Load a bubble.
  - Flush_Count += 1 only if IFID_Valid=1.
  - Bubble_Count is unchanged.
  - Branch_flush overrides IDEX_Hold and Stall_flush.
- IDEX_Hold=1 (no Branch_flush):
  - All IDEX_* outputs and counters keep their values.
  - A concurrent Stall_flush is ignored and not counted; the hazard re-evaluates next cycle.
- Stall_flush=1 (no Branch_flush, no Hold):
  - Load a bubble.
  - Bubble_Count += 1 only if IFID_Valid=1.
- Load (all controls 0):
  - All IDEX_* capture ID_* and IDEX_Valid = IFID_Valid.
  - If IFID_Valid=0, control outputs are forced to 0 and rn/rm/rd to 31; data fields are still captured.
- Counters:
  - Saturate at all-ones; no wrap-around.
  - Each counter increments at most once per cycle.
- No combinational path from any input to any output.

Test Plan:
- Reset: drive random ID_* with Reset_n=0 for 2 edges -> all IDEX_* = 0, rn/rm/rd = 31, counters 0; release, load ID_rd=5, ID_MemRead=1, IFID_Valid=1 -> next cycle IDEX_rd=5, IDEX_MemRead=1, IDEX_Valid=1.
- Load-use: a load (rd=3) is followed by an instruction with rn=3, and Stall_flush pulses 1 cycle -> IDEX_Valid=0, IDEX_MemRead=0, IDEX_rd=31, IDEX_PC unchanged, Bubble_Count=1; the next cycle loads the dependent instruction with rn=3.
- Branch flush: Branch_flush=1 and Stall_flush=1 on the same edge with IFID_Valid=1 -> bubble, Flush_Count=1, Bubble_Count=0.
- Hold: IDEX_Hold=1 for 3 cycles with changing ID_* and Stall_flush=1 -> IDEX_* frozen, Bubble_Count unchanged; release -> next ID_* captured.
- Invalid fetch: IFID_Valid=0, ID_RegWrite=1, ID_rd=7 -> IDEX_RegWrite=0, IDEX_rd=31, IDEX_Valid=0; Stall_flush in this state leaves Bubble_Count unchanged.
- Saturation (CNT_WIDTH=4 build): 20 valid Stall_flush bubbles -> Bubble_Count stops at 15.

Source files
------------

// File: rtl/idex_pipeline_register.sv
// ID/EX pipeline register: captures decoded control and operands for EX, inserts
// bubbles for load-use stalls and branch redirects, and counts both events.
module idex_pipeline_register #(
    parameter int DATA_WIDTH     = 64,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      IFID_Valid,
    input  logic                      Stall_flush,
    input  logic                      Branch_flush,
    input  logic                      IDEX_Hold,
    input  logic                      ID_RegWrite,
    input  logic                      ID_MemRead,
    input  logic                      ID_MemWrite,
    input  logic                      ID_MemToReg,
    input  logic                      ID_ALUSrc,
    input  logic                      ID_Branch,
    input  logic                      ID_UncondBranch,
    input  logic [1:0]                ID_ALUOp,
    input  logic [DATA_WIDTH-1:0]     ID_PC,
    input  logic [DATA_WIDTH-1:0]     ID_ReadData1,
    input  logic [DATA_WIDTH-1:0]     ID_ReadData2,
    input  logic [DATA_WIDTH-1:0]     ID_SignExtImm,
    input  logic [10:0]               ID_Opcode,
    input  logic [REG_ADDR_WIDTH-1:0] ID_rn,
    input  logic [REG_ADDR_WIDTH-1:0] ID_rm,
    input  logic [REG_ADDR_WIDTH-1:0] ID_rd,
    output logic                      IDEX_Valid,
    output logic                      IDEX_RegWrite,
    output logic                      IDEX_MemRead,
    output logic                      IDEX_MemWrite,
    output logic                      IDEX_MemToReg,
    output logic                      IDEX_ALUSrc,
    output logic                      IDEX_Branch,
    output logic                      IDEX_UncondBranch,
    output logic [1:0]                IDEX_ALUOp,
    output logic [DATA_WIDTH-1:0]     IDEX_PC,
    output logic [DATA_WIDTH-1:0]     IDEX_ReadData1,
    output logic [DATA_WIDTH-1:0]     IDEX_ReadData2,
    output logic [DATA_WIDTH-1:0]     IDEX_SignExtImm,
    output logic [10:0]               IDEX_Opcode,
    output logic [REG_ADDR_WIDTH-1:0] IDEX_rn,
    output logic [REG_ADDR_WIDTH-1:0] IDEX_rm,
    output logic [REG_ADDR_WIDTH-1:0] IDEX_rd,
    output logic [CNT_WIDTH-1:0]      Bubble_Count,
    output logic [CNT_WIDTH-1:0]      Flush_Count
);

    localparam logic [REG_ADDR_WIDTH-1:0] XZR     = {REG_ADDR_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]      CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]      CNT_ONE = CNT_WIDTH'(1);

    // Bubbles carry XZR specifiers so they never match a hazard or forwarding compare.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            IDEX_Valid        <= 1'b0;
            IDEX_RegWrite     <= 1'b0;
            IDEX_MemRead      <= 1'b0;
            IDEX_MemWrite     <= 1'b0;
            IDEX_MemToReg     <= 1'b0;
            IDEX_ALUSrc       <= 1'b0;
            IDEX_Branch       <= 1'b0;
            IDEX_UncondBranch <= 1'b0;
            IDEX_ALUOp        <= 2'b00;
            IDEX_PC           <= '0;
            IDEX_ReadData1    <= '0;
            IDEX_ReadData2    <= '0;
            IDEX_SignExtImm   <= '0;
            IDEX_Opcode       <= '0;
            IDEX_rn           <= XZR;
            IDEX_rm           <= XZR;
            IDEX_rd           <= XZR;
            Bubble_Count      <= '0;
            Flush_Count       <= '0;
        end else if (Branch_flush || (!IDEX_Hold && Stall_flush)) begin
            IDEX_Valid        <= 1'b0;
            IDEX_RegWrite     <= 1'b0;
            IDEX_MemRead      <= 1'b0;
            IDEX_MemWrite     <= 1'b0;
            IDEX_MemToReg     <= 1'b0;
            IDEX_ALUSrc       <= 1'b0;
            IDEX_Branch       <= 1'b0;
            IDEX_UncondBranch <= 1'b0;
            IDEX_ALUOp        <= 2'b00;
            IDEX_rn           <= XZR;
            IDEX_rm           <= XZR;
            IDEX_rd           <= XZR;
            if (Branch_flush) begin
                if (IFID_Valid && Flush_Count != CNT_MAX)
                    Flush_Count <= Flush_Count + CNT_ONE;
            end else begin
                if (IFID_Valid && Bubble_Count != CNT_MAX)
                    Bubble_Count <= Bubble_Count + CNT_ONE;
            end
        end else if (!IDEX_Hold) begin
            // Data fields are captured even for an empty slot; only control is gated.
            IDEX_Valid        <= IFID_Valid;
            IDEX_RegWrite     <= IFID_Valid & ID_RegWrite;
            IDEX_MemRead      <= IFID_Valid & ID_MemRead;
            IDEX_MemWrite     <= IFID_Valid & ID_MemWrite;
            IDEX_MemToReg     <= IFID_Valid & ID_MemToReg;
            IDEX_ALUSrc       <= IFID_Valid & ID_ALUSrc;
            IDEX_Branch       <= IFID_Valid & ID_Branch;
            IDEX_UncondBranch <= IFID_Valid & ID_UncondBranch;
            IDEX_ALUOp        <= IFID_Valid ? ID_ALUOp : 2'b00;
            IDEX_PC           <= ID_PC;
            IDEX_ReadData1    <= ID_ReadData1;
            IDEX_ReadData2    <= ID_ReadData2;
            IDEX_SignExtImm   <= ID_SignExtImm;
            IDEX_Opcode       <= ID_Opcode;
            IDEX_rn           <= IFID_Valid ? ID_rn : XZR;
            IDEX_rm           <= IFID_Valid ? ID_rm : XZR;
            IDEX_rd           <= IFID_Valid ? ID_rd : XZR;
        end
    end

endmodule

// File: tb/tb_idex_pipeline_register.sv
// Randomized and directed bench for idex_pipeline_register against a behavioural model;
// a second instance with 4-bit counters exercises counter saturation.
module tb_idex_pipeline_register;

    logic        Clk = 1'b0;
    logic        Reset_n, IFID_Valid, Stall_flush, Branch_flush, IDEX_Hold;
    logic [6:0]  id_ctl;
    logic [1:0]  ID_ALUOp;
    logic [63:0] ID_PC, ID_ReadData1, ID_ReadData2, ID_SignExtImm;
    logic [10:0] ID_Opcode;
    logic [4:0]  ID_rn, ID_rm, ID_rd;

    logic        o_valid, o_rw, o_mr, o_mw, o_m2r, o_as, o_br, o_ub;
    logic [1:0]  o_aluop;
    logic [63:0] o_pc, o_rd1, o_rd2, o_imm;
    logic [10:0] o_opc;
    logic [4:0]  o_rn, o_rm, o_rd;
    logic [31:0] o_bub, o_flu;

    logic        s_valid, s_rw, s_mr, s_mw, s_m2r, s_as, s_br, s_ub;
    logic [1:0]  s_aluop;
    logic [63:0] s_pc, s_rd1, s_rd2, s_imm;
    logic [10:0] s_opc;
    logic [4:0]  s_rn, s_rm, s_rd;
    logic [3:0]  s_bub, s_flu;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    idex_pipeline_register dut (
        .Clk(Clk), .Reset_n(Reset_n), .IFID_Valid(IFID_Valid), .Stall_flush(Stall_flush),
        .Branch_flush(Branch_flush), .IDEX_Hold(IDEX_Hold),
        .ID_RegWrite(id_ctl[6]), .ID_MemRead(id_ctl[5]), .ID_MemWrite(id_ctl[4]),
        .ID_MemToReg(id_ctl[3]), .ID_ALUSrc(id_ctl[2]), .ID_Branch(id_ctl[1]),
        .ID_UncondBranch(id_ctl[0]), .ID_ALUOp(ID_ALUOp), .ID_PC(ID_PC),
        .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_SignExtImm(ID_SignExtImm),
        .ID_Opcode(ID_Opcode), .ID_rn(ID_rn), .ID_rm(ID_rm), .ID_rd(ID_rd),
        .IDEX_Valid(o_valid), .IDEX_RegWrite(o_rw), .IDEX_MemRead(o_mr), .IDEX_MemWrite(o_mw),
        .IDEX_MemToReg(o_m2r), .IDEX_ALUSrc(o_as), .IDEX_Branch(o_br), .IDEX_UncondBranch(o_ub),
        .IDEX_ALUOp(o_aluop), .IDEX_PC(o_pc), .IDEX_ReadData1(o_rd1), .IDEX_ReadData2(o_rd2),
        .IDEX_SignExtImm(o_imm), .IDEX_Opcode(o_opc), .IDEX_rn(o_rn), .IDEX_rm(o_rm),
        .IDEX_rd(o_rd), .Bubble_Count(o_bub), .Flush_Count(o_flu)
    );

    idex_pipeline_register #(.CNT_WIDTH(4)) dut_small (
        .Clk(Clk), .Reset_n(Reset_n), .IFID_Valid(IFID_Valid), .Stall_flush(Stall_flush),
        .Branch_flush(Branch_flush), .IDEX_Hold(IDEX_Hold),
        .ID_RegWrite(id_ctl[6]), .ID_MemRead(id_ctl[5]), .ID_MemWrite(id_ctl[4]),
        .ID_MemToReg(id_ctl[3]), .ID_ALUSrc(id_ctl[2]), .ID_Branch(id_ctl[1]),
        .ID_UncondBranch(id_ctl[0]), .ID_ALUOp(ID_ALUOp), .ID_PC(ID_PC),
        .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_SignExtImm(ID_SignExtImm),
        .ID_Opcode(ID_Opcode), .ID_rn(ID_rn), .ID_rm(ID_rm), .ID_rd(ID_rd),
        .IDEX_Valid(s_valid), .IDEX_RegWrite(s_rw), .IDEX_MemRead(s_mr), .IDEX_MemWrite(s_mw),
        .IDEX_MemToReg(s_m2r), .IDEX_ALUSrc(s_as), .IDEX_Branch(s_br), .IDEX_UncondBranch(s_ub),
        .IDEX_ALUOp(s_aluop), .IDEX_PC(s_pc), .IDEX_ReadData1(s_rd1), .IDEX_ReadData2(s_rd2),
        .IDEX_SignExtImm(s_imm), .IDEX_Opcode(s_opc), .IDEX_rn(s_rn), .IDEX_rm(s_rm),
        .IDEX_rd(s_rd), .Bubble_Count(s_bub), .Flush_Count(s_flu)
    );

    // Reference model: one record describing what EX should see.
    typedef struct {
        bit        valid;
        bit [6:0]  ctl;
        bit [1:0]  aluop;
        bit [63:0] pc, rd1, rd2, imm;
        bit [10:0] opc;
        bit [4:0]  rn, rm, rd;
        longint    bubbles, flushes;
    } exp_t;

    exp_t m;
    bit   model_ok = 1'b0;

    function automatic longint sat(longint v, longint cap);
        return (v > cap) ? cap : v;
    endfunction

    always @(posedge Clk) begin
        if (!Reset_n) begin
            m = '{valid: 0, ctl: 0, aluop: 0, pc: 0, rd1: 0, rd2: 0, imm: 0, opc: 0,
                  rn: 31, rm: 31, rd: 31, bubbles: 0, flushes: 0};
            model_ok = 1'b1;
        end else if (Branch_flush || (!IDEX_Hold && Stall_flush)) begin
            m.valid = 0; m.ctl = 0; m.aluop = 0; m.rn = 31; m.rm = 31; m.rd = 31;
            if (Branch_flush) m.flushes += IFID_Valid;
            else              m.bubbles += IFID_Valid;
        end else if (!IDEX_Hold) begin
            m.valid = IFID_Valid;
            m.ctl   = IFID_Valid ? id_ctl : 7'd0;
            m.aluop = IFID_Valid ? ID_ALUOp : 2'd0;
            m.pc = ID_PC; m.rd1 = ID_ReadData1; m.rd2 = ID_ReadData2;
            m.imm = ID_SignExtImm; m.opc = ID_Opcode;
            m.rn = IFID_Valid ? ID_rn : 5'd31;
            m.rm = IFID_Valid ? ID_rm : 5'd31;
            m.rd = IFID_Valid ? ID_rd : 5'd31;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (model_ok) begin
            chk("valid", {63'd0, o_valid}, {63'd0, m.valid});
            chk("ctl", {57'd0, o_rw, o_mr, o_mw, o_m2r, o_as, o_br, o_ub}, {57'd0, m.ctl});
            chk("aluop", {62'd0, o_aluop}, {62'd0, m.aluop});
            chk("pc", o_pc, m.pc);
            chk("rd1", o_rd1, m.rd1);
            chk("rd2", o_rd2, m.rd2);
            chk("imm", o_imm, m.imm);
            chk("opcode", {53'd0, o_opc}, {53'd0, m.opc});
            chk("regs", {49'd0, o_rn, o_rm, o_rd}, {49'd0, m.rn, m.rm, m.rd});
            chk("bubble_cnt", {32'd0, o_bub}, sat(m.bubbles, 64'hFFFF_FFFF));
            chk("flush_cnt", {32'd0, o_flu}, sat(m.flushes, 64'hFFFF_FFFF));
            chk("small_bubble_cnt", {60'd0, s_bub}, sat(m.bubbles, 15));
            chk("small_flush_cnt", {60'd0, s_flu}, sat(m.flushes, 15));
            chk("small_pipe", {s_valid, s_rw, s_mr, s_rd, s_pc[15:0]},
                {o_valid, o_rw, o_mr, o_rd, o_pc[15:0]});
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic rand_id();
        id_ctl        = 7'($urandom);
        ID_ALUOp      = 2'($urandom);
        ID_PC         = {$urandom, $urandom};
        ID_ReadData1  = {$urandom, $urandom};
        ID_ReadData2  = {$urandom, $urandom};
        ID_SignExtImm = {$urandom, $urandom};
        ID_Opcode     = 11'($urandom);
        ID_rn         = 5'($urandom);
        ID_rm         = 5'($urandom);
        ID_rd         = 5'($urandom);
    endtask

    task automatic quiet();
        Stall_flush = 0; Branch_flush = 0; IDEX_Hold = 0;
    endtask

    initial begin
        Reset_n = 0; IFID_Valid = 1; quiet(); rand_id();

        // Reset with random ID inputs
        tick(); rand_id(); tick();
        chk("rst_rd", {59'd0, o_rd}, 64'd31);
        chk("rst_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_pc", o_pc, 64'd0);
        chk("rst_bub", {32'd0, o_bub}, 64'd0);
        Reset_n = 1; rand_id(); id_ctl = 7'b0100000; ID_rd = 5;
        tick();
        chk("rel_rd", {59'd0, o_rd}, 64'd5);
        chk("rel_memread", {63'd0, o_mr}, 64'd1);
        chk("rel_valid", {63'd0, o_valid}, 64'd1);

        // Load-use bubble
        rand_id(); id_ctl = 7'b0100000; ID_rd = 3; ID_PC = 64'h100;
        tick();
        rand_id(); id_ctl = 7'b1000000; ID_rn = 3; ID_PC = 64'h104; Stall_flush = 1;
        tick();
        chk("lu_valid", {63'd0, o_valid}, 64'd0);
        chk("lu_memread", {63'd0, o_mr}, 64'd0);
        chk("lu_rd", {59'd0, o_rd}, 64'd31);
        chk("lu_pc", o_pc, 64'h100);
        chk("lu_bub", {32'd0, o_bub}, 64'd1);
        Stall_flush = 0;
        tick();
        chk("lu_dep_rn", {59'd0, o_rn}, 64'd3);
        chk("lu_dep_pc", o_pc, 64'h104);

        // Branch flush overrides a simultaneous stall
        Reset_n = 0; tick(); Reset_n = 1;
        rand_id(); Branch_flush = 1; Stall_flush = 1; IFID_Valid = 1;
        tick();
        chk("bf_valid", {63'd0, o_valid}, 64'd0);
        chk("bf_flush", {32'd0, o_flu}, 64'd1);
        chk("bf_bub", {32'd0, o_bub}, 64'd0);
        quiet();

        // Hold freezes everything and swallows a stall
        rand_id(); ID_PC = 64'h200; tick();
        IDEX_Hold = 1; Stall_flush = 1;
        for (int i = 0; i < 3; i++) begin
            rand_id(); tick();
            chk("hold_pc", o_pc, 64'h200);
            chk("hold_bub", {32'd0, o_bub}, 64'd0);
        end
        quiet(); rand_id(); ID_PC = 64'h300; tick();
        chk("hold_rel_pc", o_pc, 64'h300);

        // Empty fetch slot
        rand_id(); IFID_Valid = 0; id_ctl[6] = 1; ID_rd = 7; tick();
        chk("inv_rw", {63'd0, o_rw}, 64'd0);
        chk("inv_rd", {59'd0, o_rd}, 64'd31);
        chk("inv_valid", {63'd0, o_valid}, 64'd0);
        Stall_flush = 1; tick();
        chk("inv_bub", {32'd0, o_bub}, 64'd0);
        quiet(); IFID_Valid = 1;

        // Saturation of the 4-bit counter build
        Reset_n = 0; tick(); Reset_n = 1;
        Stall_flush = 1;
        for (int i = 0; i < 20; i++) begin rand_id(); tick(); end
        chk("sat_small", {60'd0, s_bub}, 64'd15);
        chk("sat_big", {32'd0, o_bub}, 64'd20);
        quiet();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rand_id();
            Reset_n      = ($urandom_range(0, 99) >= 2);
            Branch_flush = ($urandom_range(0, 99) < 10);
            IDEX_Hold    = ($urandom_range(0, 99) < 15);
            Stall_flush  = ($urandom_range(0, 99) < 25);
            IFID_Valid   = ($urandom_range(0, 99) < 80);
            tick();
        end
        quiet();
        @(negedge Clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
